// File: rtl/mem_stage.sv
// MIPS MEM stage. Holds the EX/MEM pipeline register, decodes loads and stores,
// detects address exceptions, runs the req/ready data-memory handshake with a
// timeout, and sign/zero-extends load data for writeback.
module mem_stage #(
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] Instr_EX,
    input  logic [31:0] PC_EX,
    input  logic [31:0] ALUout_EX,
    input  logic [31:0] RtData_EX,
    input  logic [4:0]  RegA3_EX,
    input  logic        Overflow_EX,
    input  logic [4:0]  ExcCode_EX,
    output logic        busy_MEM,
    output logic [31:0] Instr_MEM,
    output logic [31:0] PC_MEM,
    output logic [31:0] ALUout_MEM,
    output logic [4:0]  RegA3_MEM,
    output logic [31:0] MemOut_MEM,
    output logic [4:0]  ExcCode_MEM,
    output logic [31:0] BadVAddr_MEM,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_BUS  = 5'd7;

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_FAULT} state_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    // Exception code for one instruction: an incoming code passes unchanged,
    // otherwise a bad load/store address yields AdEL/AdES.
    function automatic logic [4:0] exc_code(input logic [31:0] instr,
                                            input logic [31:0] addr,
                                            input logic        ovf,
                                            input logic [4:0]  exc_in);
        logic [5:0] op;
        logic       misaligned;
        op = instr[31:26];
        case (op)
            OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
            default:              misaligned = 1'b0;
        endcase
        if (exc_in != 5'd0)
            return exc_in;
        if (!(is_load(op) || is_store(op)))
            return 5'd0;
        if (misaligned || ovf || (addr >= ADDR_LIMIT))
            return is_load(op) ? EXC_ADEL : EXC_ADES;
        return 5'd0;
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [31:0]        r_instr, r_pc, r_alu, r_rt;
    logic [4:0]         r_a3, r_exc_in;
    logic               r_ovf;
    logic [5:0]         w_op;
    logic [4:0]         w_exc;
    logic               w_ex_start;
    logic [7:0]         w_rd_byte;
    logic [15:0]        w_rd_half;

    assign w_op       = r_instr[31:26];
    assign w_exc      = exc_code(r_instr, r_alu, r_ovf, r_exc_in);
    assign w_ex_start = (is_load(Instr_EX[31:26]) || is_store(Instr_EX[31:26])) &&
                        (exc_code(Instr_EX, ALUout_EX, Overflow_EX, ExcCode_EX) == 5'd0);

    assign Instr_MEM  = r_instr;
    assign PC_MEM     = r_pc;
    assign ALUout_MEM = r_alu;
    assign RegA3_MEM  = r_a3;

    // State register and ACCESS wait counter
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: start an access when a clean load/store enters, time out on a stuck memory
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (flush) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                S_ACCESS: begin
                    if (mem_ready) begin
                        w_state_next = w_ex_start ? S_ACCESS : S_IDLE;
                        w_cnt_next   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next = S_FAULT;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = w_ex_start ? S_ACCESS : S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // EX/MEM pipeline register: flush makes a bubble, stall holds, otherwise load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr  <= '0;
            r_pc     <= '0;
            r_alu    <= '0;
            r_rt     <= '0;
            r_a3     <= '0;
            r_ovf    <= 1'b0;
            r_exc_in <= '0;
        end else if (flush) begin
            r_instr  <= '0;
            r_pc     <= '0;
            r_alu    <= '0;
            r_rt     <= '0;
            r_a3     <= '0;
            r_ovf    <= 1'b0;
            r_exc_in <= '0;
        end else if (!busy_MEM) begin
            r_instr  <= Instr_EX;
            r_pc     <= PC_EX;
            r_alu    <= ALUout_EX;
            r_rt     <= RtData_EX;
            r_a3     <= RegA3_EX;
            r_ovf    <= Overflow_EX;
            r_exc_in <= ExcCode_EX;
        end
    end

    // Memory port, store lanes, load extension and exception reporting
    always_comb begin
        mem_req      = (r_state == S_ACCESS);
        busy_MEM     = mem_req && !mem_ready;
        mem_addr     = {r_alu[31:2], 2'b00};
        mem_be       = 4'b0000;
        mem_wdata    = 32'h0;
        MemOut_MEM   = 32'h0;
        ExcCode_MEM  = (r_state == S_FAULT) ? EXC_BUS : w_exc;
        BadVAddr_MEM = 32'h0;
        w_rd_byte    = mem_rdata[{r_alu[1:0], 3'b000} +: 8];
        w_rd_half    = r_alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (w_op)
            OP_SW:   mem_wdata = r_rt;
            OP_SH:   mem_wdata = {2{r_rt[15:0]}};
            OP_SB:   mem_wdata = {4{r_rt[7:0]}};
            default: mem_wdata = 32'h0;
        endcase

        // A flushed cycle must never present write enables to the memory.
        if (mem_req && !flush) begin
            case (w_op)
                OP_SW:   mem_be = 4'b1111;
                OP_SH:   mem_be = r_alu[1] ? 4'b1100 : 4'b0011;
                OP_SB:   mem_be = 4'b0001 << r_alu[1:0];
                default: mem_be = 4'b0000;
            endcase
        end

        if (mem_req && mem_ready) begin
            case (w_op)
                OP_LW:   MemOut_MEM = mem_rdata;
                OP_LH:   MemOut_MEM = {{16{w_rd_half[15]}}, w_rd_half};
                OP_LHU:  MemOut_MEM = {16'h0, w_rd_half};
                OP_LB:   MemOut_MEM = {{24{w_rd_byte[7]}}, w_rd_byte};
                OP_LBU:  MemOut_MEM = {24'h0, w_rd_byte};
                default: MemOut_MEM = 32'h0;
            endcase
        end

        if (ExcCode_MEM inside {EXC_ADEL, EXC_ADES, EXC_BUS})
            BadVAddr_MEM = r_alu;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// loads/stores compared against a byte-lane arithmetic reference model.
module tb_mem_stage;

    localparam int TO = 16;
    localparam logic [5:0] LW = 6'h23, LH = 6'h21, LHU = 6'h25, LB = 6'h20, LBU = 6'h24;
    localparam logic [5:0] SW = 6'h2B, SH = 6'h29, SB = 6'h28;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [31:0] Instr_EX, PC_EX, ALUout_EX, RtData_EX;
    logic [4:0]  RegA3_EX, ExcCode_EX;
    logic        Overflow_EX;
    logic        busy_MEM;
    logic [31:0] Instr_MEM, PC_MEM, ALUout_MEM, MemOut_MEM, BadVAddr_MEM;
    logic [4:0]  RegA3_MEM, ExcCode_MEM;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ready;

    int n_pass  = 0;
    int n_total = 0;

    mem_stage #(.TIMEOUT(TO), .ADDR_LIMIT(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .Instr_EX(Instr_EX), .PC_EX(PC_EX), .ALUout_EX(ALUout_EX),
        .RtData_EX(RtData_EX), .RegA3_EX(RegA3_EX), .Overflow_EX(Overflow_EX),
        .ExcCode_EX(ExcCode_EX), .busy_MEM(busy_MEM), .Instr_MEM(Instr_MEM),
        .PC_MEM(PC_MEM), .ALUout_MEM(ALUout_MEM), .RegA3_MEM(RegA3_MEM),
        .MemOut_MEM(MemOut_MEM), .ExcCode_MEM(ExcCode_MEM),
        .BadVAddr_MEM(BadVAddr_MEM), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int unsigned access_size(input logic [5:0] op);
        case (op)
            LW, SW:      return 4;
            LH, LHU, SH: return 2;
            LB, LBU, SB: return 1;
            default:     return 0;
        endcase
    endfunction

    function automatic bit is_ld(input logic [5:0] op);
        return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
    endfunction

    function automatic logic [4:0] exp_exc(input logic [5:0] op, input logic [31:0] addr,
                                           input logic ovf, input logic [4:0] ein);
        int unsigned size;
        if (ein != 5'd0) return ein;
        size = access_size(op);
        if (size == 0) return 5'd0;
        if (ovf || (addr % size) != 0 || addr >= 32'h3000) return is_ld(op) ? 5'd4 : 5'd5;
        return 5'd0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned sh;
        longint      v;
        sh = (addr % 4) * 8;
        v  = 0;
        case (op)
            LW:      v = rdata;
            LB, LBU: begin
                v = (rdata >> sh) % 256;
                if (op == LB && v >= 128) v = v - 256;
            end
            LH, LHU: begin
                v = (rdata >> sh) % 65536;
                if (op == LH && v >= 32768) v = v - 65536;
            end
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [3:0] exp_be(input logic [5:0] op, input logic [31:0] addr);
        case (op)
            SW:      return 4'hF;
            SH:      return 4'(3 << (addr % 4));
            SB:      return 4'(1 << (addr % 4));
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] rt);
        case (op)
            SW:      return rt;
            SH:      return 32'((rt % 65536) * 32'h0001_0001);
            SB:      return 32'((rt % 256) * 32'h0101_0101);
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic ovf, input logic [4:0] ein);
        Instr_EX    = {op, 26'($urandom)};
        PC_EX       = $urandom;
        ALUout_EX   = addr;
        RtData_EX   = rt;
        RegA3_EX    = 5'($urandom);
        Overflow_EX = ovf;
        ExcCode_EX  = ein;
    endtask

    task automatic set_bubble();
        Instr_EX    = 32'h0;
        PC_EX       = 32'h0;
        ALUout_EX   = 32'h0;
        RtData_EX   = 32'h0;
        RegA3_EX    = 5'h0;
        Overflow_EX = 1'b0;
        ExcCode_EX  = 5'h0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0;
        set_ex(SW, 32'h100, 32'hFFFF_FFFF, 1'b0, 5'd0);
        tick();
        tick();
        n_total++; if ({mem_req, busy_MEM, mem_be} !== 6'h0) $display("FAIL reset_port: got %h want 0", {mem_req, busy_MEM, mem_be}); else n_pass++;
        n_total++; if ({ExcCode_MEM, BadVAddr_MEM} !== 37'h0) $display("FAIL reset_exc: got %h want 0", {ExcCode_MEM, BadVAddr_MEM}); else n_pass++;
        n_total++; if ({Instr_MEM, ALUout_MEM, MemOut_MEM} !== 96'h0) $display("FAIL reset_regs: got %h want 0", {Instr_MEM, ALUout_MEM, MemOut_MEM}); else n_pass++;
        set_bubble();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sw_single_cycle();
        set_ex(SW, 32'h100, 32'h1234_5678, 1'b0, 5'd0);
        mem_ready = 1'b1;
        tick();
        set_bubble();
        #1;
        n_total++; if (mem_req !== 1'b1) $display("FAIL sw_req: got %b want 1", mem_req); else n_pass++;
        n_total++; if (mem_addr !== 32'h100) $display("FAIL sw_addr: got %h want 00000100", mem_addr); else n_pass++;
        n_total++; if (mem_be !== 4'b1111) $display("FAIL sw_be: got %b want 1111", mem_be); else n_pass++;
        n_total++; if (mem_wdata !== 32'h1234_5678) $display("FAIL sw_wdata: got %h want 12345678", mem_wdata); else n_pass++;
        n_total++; if (busy_MEM !== 1'b0) $display("FAIL sw_busy: got %b want 0", busy_MEM); else n_pass++;
        tick();
        n_total++; if (mem_req !== 1'b0) $display("FAIL sw_after_req: got %b want 0", mem_req); else n_pass++;
    endtask

    task automatic test_load_extend();
        logic [5:0]  ops  [3];
        logic [31:0] adrs [3];
        logic [31:0] outs [3];
        ops  = '{LB, LBU, LH};
        adrs = '{32'h203, 32'h203, 32'h202};
        outs = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
        mem_rdata = 32'h80FF_0011;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ex(ops[i], adrs[i], 32'h0, 1'b0, 5'd0);
            tick();
            set_bubble();
            #1;
            n_total++; if (MemOut_MEM !== outs[i]) $display("FAIL load_ext[%0d]: got %h want %h", i, MemOut_MEM, outs[i]); else n_pass++;
            n_total++; if (busy_MEM !== 1'b0) $display("FAIL load_busy[%0d]: got %b want 0", i, busy_MEM); else n_pass++;
            tick();
        end
    endtask

    task automatic test_addr_exc();
        logic [5:0]  ops  [4];
        logic [31:0] adrs [4];
        logic        ovfs [4];
        logic [4:0]  eins [4];
        logic [4:0]  codes[4];
        logic [31:0] bads [4];
        ops   = '{LW, SH, LW, LW};
        adrs  = '{32'h102, 32'h3000, 32'h102, 32'h100};
        ovfs  = '{1'b0, 1'b0, 1'b0, 1'b1};
        eins  = '{5'd0, 5'd0, 5'd10, 5'd0};
        codes = '{5'd4, 5'd5, 5'd10, 5'd4};
        bads  = '{32'h102, 32'h3000, 32'h0, 32'h100};
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ex(ops[i], adrs[i], 32'hA5A5_A5A5, ovfs[i], eins[i]);
            tick();
            set_bubble();
            #1;
            n_total++; if (ExcCode_MEM !== codes[i]) $display("FAIL exc_code[%0d]: got %0d want %0d", i, ExcCode_MEM, codes[i]); else n_pass++;
            n_total++; if (BadVAddr_MEM !== bads[i]) $display("FAIL exc_badvaddr[%0d]: got %h want %h", i, BadVAddr_MEM, bads[i]); else n_pass++;
            n_total++; if ({mem_req, mem_be} !== 5'h0) $display("FAIL exc_noreq[%0d]: got %h want 0", i, {mem_req, mem_be}); else n_pass++;
            tick();
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] lw_instr, lw_pc, sw_instr;
        logic [4:0]  lw_a3;
        mem_ready = 1'b0;
        set_ex(LW, 32'h204, 32'h0, 1'b0, 5'd0);
        lw_instr = Instr_EX; lw_pc = PC_EX; lw_a3 = RegA3_EX;
        tick();
        set_ex(SW, 32'h300, 32'hCAFE_F00D, 1'b0, 5'd0);
        sw_instr = Instr_EX;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++; if ({busy_MEM, mem_req} !== 2'b11) $display("FAIL wait_busy[%0d]: got %b want 11", c, {busy_MEM, mem_req}); else n_pass++;
            n_total++; if ({Instr_MEM, PC_MEM, RegA3_MEM} !== {lw_instr, lw_pc, lw_a3}) $display("FAIL wait_hold[%0d]: got %h want %h", c, Instr_MEM, lw_instr); else n_pass++;
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        n_total++; if (busy_MEM !== 1'b0) $display("FAIL wait_release: got %b want 0", busy_MEM); else n_pass++;
        n_total++; if (MemOut_MEM !== 32'hDEAD_BEEF) $display("FAIL wait_data: got %h want deadbeef", MemOut_MEM); else n_pass++;
        tick();
        set_bubble();
        #1;
        n_total++; if (Instr_MEM !== sw_instr) $display("FAIL wait_advance: got %h want %h", Instr_MEM, sw_instr); else n_pass++;
        n_total++; if ({mem_req, mem_be, mem_wdata} !== {1'b1, 4'hF, 32'hCAFE_F00D}) $display("FAIL wait_next_store: got %h want 1fcafef00d", {mem_req, mem_be, mem_wdata}); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        mem_ready = 1'b1;
        rd = $urandom;
        mem_rdata = rd;
        set_ex(SW, 32'h010, 32'h1111_2222, 1'b0, 5'd0);
        tick();
        set_ex(SB, 32'h022, 32'h0000_00C3, 1'b0, 5'd0);
        #1;
        n_total++; if ({mem_be, mem_wdata} !== {4'hF, 32'h1111_2222}) $display("FAIL b2b_first: got %h want f11112222", {mem_be, mem_wdata}); else n_pass++;
        tick();
        set_ex(LBU, 32'h031, 32'h0, 1'b0, 5'd0);
        #1;
        n_total++; if ({mem_be, mem_wdata, mem_addr} !== {exp_be(SB, 32'h022), exp_wdata(SB, 32'hC3), 32'h020}) $display("FAIL b2b_second: got %h want %h", {mem_be, mem_wdata}, {exp_be(SB, 32'h022), exp_wdata(SB, 32'hC3)}); else n_pass++;
        tick();
        set_bubble();
        #1;
        n_total++; if (MemOut_MEM !== exp_load(LBU, 32'h031, rd)) $display("FAIL b2b_third: got %h want %h", MemOut_MEM, exp_load(LBU, 32'h031, rd)); else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        int access_cycles;
        access_cycles = 0;
        mem_ready = 1'b0;
        set_ex(SW, 32'h40, 32'h5555_AAAA, 1'b0, 5'd0);
        tick();
        set_bubble();
        for (int c = 0; c < TO; c++) begin
            #1;
            if (mem_req === 1'b1 && busy_MEM === 1'b1 && ExcCode_MEM === 5'd0) access_cycles++;
            tick();
        end
        n_total++; if (access_cycles !== TO) $display("FAIL timeout_access: got %0d want %0d", access_cycles, TO); else n_pass++;
        #1;
        n_total++; if (ExcCode_MEM !== 5'd7) $display("FAIL timeout_code: got %0d want 7", ExcCode_MEM); else n_pass++;
        n_total++; if ({mem_req, busy_MEM, mem_be} !== 6'h0) $display("FAIL timeout_port: got %h want 0", {mem_req, busy_MEM, mem_be}); else n_pass++;
        n_total++; if (BadVAddr_MEM !== 32'h40) $display("FAIL timeout_badvaddr: got %h want 00000040", BadVAddr_MEM); else n_pass++;
        tick();
        n_total++; if ({ExcCode_MEM, mem_req} !== 6'h0) $display("FAIL timeout_after: got %h want 0", {ExcCode_MEM, mem_req}); else n_pass++;
    endtask

    task automatic test_flush();
        mem_ready = 1'b0;
        set_ex(SW, 32'h80, 32'h7777_8888, 1'b0, 5'd0);
        tick();
        set_bubble();
        tick();
        flush = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_total++; if ({mem_req, mem_be} !== {1'b1, 4'h0}) $display("FAIL flush_be: got %h want 10", {mem_req, mem_be}); else n_pass++;
        tick();
        flush = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_total++; if ({mem_req, busy_MEM, mem_be, ExcCode_MEM} !== 11'h0) $display("FAIL flush_port: got %h want 0", {mem_req, busy_MEM, mem_be, ExcCode_MEM}); else n_pass++;
        n_total++; if ({Instr_MEM, ALUout_MEM, BadVAddr_MEM} !== 96'h0) $display("FAIL flush_regs: got %h want 0", {Instr_MEM, ALUout_MEM, BadVAddr_MEM}); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_access();
        mem_ready = 1'b0;
        set_ex(SW, 32'h10, 32'h9999_0000, 1'b0, 5'd0);
        tick();
        set_bubble();
        #2;
        reset = 1'b1;
        #1;
        n_total++; if ({mem_req, busy_MEM, mem_be} !== 6'h0) $display("FAIL rstmid_port: got %h want 0", {mem_req, busy_MEM, mem_be}); else n_pass++;
        n_total++; if ({Instr_MEM, ALUout_MEM} !== 64'h0) $display("FAIL rstmid_regs: got %h want 0", {Instr_MEM, ALUout_MEM}); else n_pass++;
        tick();
        reset = 1'b0;
        tick();
        n_total++; if (mem_req !== 1'b0) $display("FAIL rstmid_after: got %b want 0", mem_req); else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0]  ops [9];
        logic [5:0]  op;
        logic [31:0] addr, rt, rd;
        logic        ovf;
        logic [4:0]  ein, e;
        int unsigned size;
        int          d;
        ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, 6'h00};
        for (int it = 0; it < 80; it++) begin
            op   = ops[$urandom_range(0, 8)];
            size = access_size(op);
            addr = $urandom_range(0, 32'h33FF);
            if (size != 0 && $urandom_range(0, 3) != 0) addr = addr - (addr % size);
            ovf  = ($urandom_range(0, 15) == 0);
            ein  = ($urandom_range(0, 15) == 0) ? 5'd12 : 5'd0;
            rt   = $urandom;
            e    = exp_exc(op, addr, ovf, ein);
            mem_ready = 1'b0;
            set_ex(op, addr, rt, ovf, ein);
            tick();
            set_bubble();
            if (e != 5'd0 || size == 0) begin
                #1;
                n_total++; if (ExcCode_MEM !== e) $display("FAIL rnd_exc[%0d]: got %0d want %0d", it, ExcCode_MEM, e); else n_pass++;
                n_total++; if ({mem_req, busy_MEM, mem_be} !== 6'h0) $display("FAIL rnd_noreq[%0d]: got %h want 0", it, {mem_req, busy_MEM, mem_be}); else n_pass++;
                n_total++; if (BadVAddr_MEM !== ((e == 5'd4 || e == 5'd5) ? addr : 32'h0)) $display("FAIL rnd_bad[%0d]: got %h addr %h", it, BadVAddr_MEM, addr); else n_pass++;
                tick();
            end else begin
                d = $urandom_range(0, 3);
                for (int w = 0; w < d; w++) begin
                    #1;
                    n_total++; if ({mem_req, busy_MEM} !== 2'b11) $display("FAIL rnd_wait[%0d]: got %b want 11", it, {mem_req, busy_MEM}); else n_pass++;
                    tick();
                end
                rd = $urandom;
                mem_rdata = rd;
                mem_ready = 1'b1;
                #1;
                n_total++; if ({busy_MEM, mem_addr} !== {1'b0, addr - (addr % 4)}) $display("FAIL rnd_addr[%0d]: got %h want %h", it, mem_addr, addr - (addr % 4)); else n_pass++;
                if (is_ld(op)) begin
                    n_total++; if ({MemOut_MEM, mem_be} !== {exp_load(op, addr, rd), 4'h0}) $display("FAIL rnd_load[%0d]: got %h want %h", it, MemOut_MEM, exp_load(op, addr, rd)); else n_pass++;
                end else begin
                    n_total++; if ({mem_be, mem_wdata} !== {exp_be(op, addr), exp_wdata(op, rt)}) $display("FAIL rnd_store[%0d]: got %h want %h", it, {mem_be, mem_wdata}, {exp_be(op, addr), exp_wdata(op, rt)}); else n_pass++;
                end
                tick();
            end
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sw_single_cycle();
        test_load_extend();
        test_addr_exc();
        test_wait_states();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline MEM stage, directly downstream of the EX stage.
- Holds the EX/MEM pipeline register and decodes load/store from the latched instruction.
- Detects address exceptions and drives a req/ready data-memory port with byte enables. Extends load data for writeback.
- Stalls the upstream pipeline while a memory access is outstanding; raises a bus-error exception on memory timeout.

Parameters:
- TIMEOUT, 16: maximum ACCESS cycles without mem_ready before a bus error is raised (must be ≥2).
- ADDR_LIMIT, 32'h0000_3000: valid data addresses are [0, ADDR_LIMIT); loads/stores outside this range take an address exception.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  exception/eret flush: MEM register becomes a bubble
- Instr_EX  in  32  instruction from EX
- PC_EX  in  32  PC from EX
- ALUout_EX  in  32  ALU result / effective address from EX
- RtData_EX  in  32  forwarded store data
- RegA3_EX  in  5  destination register from EX
- Overflow_EX  in  1  ALU overflow from EX (address-calc overflow for load/store)
- ExcCode_EX  in  5  exception code from EX (0 = none)
- busy_MEM  out  1  upstream stall request
- Instr_MEM, PC_MEM, ALUout_MEM  out  32  latched fields
- RegA3_MEM  out  5  latched destination register
- MemOut_MEM  out  32  extended load data, valid when busy_MEM=0
- ExcCode_MEM  out  5  final exception code
- BadVAddr_MEM  out  32  faulting address (ALUout_MEM when code is 4/5/7, else 0)
- mem_req  out  1  memory request
- mem_addr  out  32  word-aligned address: {ALUout_MEM[31:2],2'b00}
- mem_be  out  4  byte write enables (0 for loads)
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, valid when mem_req && mem_ready
- mem_ready  in  1  transfer completes on any cycle where mem_req && mem_ready

Behaviour:
- Reset (async): all MEM register fields 0; state IDLE; counter 0. Outputs: mem_req=0, busy_MEM=0, mem_be=0, ExcCode_MEM=0, BadVAddr_MEM=0.
- Register update, priority: flush > hold > load.
  - flush: all fields ← 0 (bubble); next state IDLE.
  - hold: register holds while busy_MEM=1.
  - load: otherwise, latch all *_EX inputs.
- Decode on Instr_MEM[31:26]:
  - loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24
  - stores: sw 0x2B, sh 0x29, sb 0x28
- Address exception (latched ExcCode_EX == 0 only):
  - condition: word access with addr[1:0]≠0, half access with addr[0]≠0, latched Overflow, or addr ≥ ADDR_LIMIT
  - code: load → 4 (AdEL), store → 5 (AdES)
  - a nonzero incoming code always wins unchanged.
- Any exception suppresses the access: no mem_req, nothing committed.
- FSM states: IDLE, ACCESS, FAULT.
  - next state at a load edge: ACCESS if the latched instruction is a load/store with no exception, else IDLE.
  - ACCESS: mem_req=1; busy_MEM = ~mem_ready.
    - On ready: transfer completes; pipeline advances the same edge. Zero-wait memory therefore gives single-cycle MEM.
    - Wait counter increments each non-ready ACCESS cycle. On reaching TIMEOUT-1 with no ready → FAULT.
  - FAULT (one cycle): mem_req=0, busy_MEM=0, ExcCode_MEM=7, BadVAddr_MEM=address. The next instruction loads at this edge.
  - IDLE: mem_req=0, busy_MEM=0.
- Dropping mem_req before ready (flush or timeout) is a legal abort; memory must not commit the store.
- Store data and enables:
  - sw: be=1111, wdata=rt
  - sh: be = addr[1] ? 1100 : 0011; wdata={2{rt[15:0]}}
  - sb: be=0001<<addr[1:0]; wdata={4{rt[7:0]}}
- Load extension: select byte/half of mem_rdata by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through. MemOut_MEM = 0 when not a completing load.
- Simultaneous events:
  - flush in the same cycle as mem_ready: flush wins, the access is aborted and the store is not committed (mem_req falls next cycle; the ready-cycle handshake is still the commit point, so the memory commits only if flush=0).
  - Memory gates its commit with ~flush via the top level; this block also forces mem_be=0 whenever flush=1.

Test Plan:
- sw rt=0x12345678, addr 0x100, mem_ready tied 1 → single cycle: mem_req=1, mem_addr=0x100, be=1111, wdata=0x12345678, busy_MEM=0.
- lb addr 0x203, mem_rdata=0x80FF_0011 → MemOut_MEM=0xFFFF_FF80; lbu at the same address → 0x0000_0080; lh addr 0x202 → 0xFFFF_80FF.
- lw addr 0x102 → ExcCode_MEM=4, BadVAddr_MEM=0x102, mem_req=0; sh addr 0x3000 → ExcCode_MEM=5; ExcCode_EX=10 with misaligned lw → ExcCode_MEM stays 10.
- lw with mem_ready low for 3 cycles, then high → busy_MEM=1 for 3 cycles, upstream register holds, data captured on cycle 4.
- TIMEOUT=16, mem_ready held low → after 16 ACCESS cycles one FAULT cycle with ExcCode_MEM=7, mem_req=0, busy_MEM=0.
- reset or flush asserted mid-ACCESS → mem_req=0 immediately (reset) / next cycle (flush); all outputs 0; no store commit.
